// File: rtl/fft_frame_ctrl.sv
// FFT frame sequencer: gates decimated samples into the window, waits for the transform, streams bins out.
// Define FFT_PEAK_HOLD_EN to add a per-bin peak-hold array and the hold_clr input.
module fft_frame_ctrl #(
  parameter int RN   = 16,
  parameter int SIZE = 64,
  parameter int DIV  = 1,
  parameter int LAT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    abort,
  input  logic                    smpl_valid,
  output logic                    smpl_en,
  input  logic                    fft_done,
  output logic                    fft_shift,
  input  logic [RN-1:0]           fft_data,
  output logic [RN-1:0]           bin_data,
  output logic [$clog2(SIZE)-1:0] bin_idx,
  output logic                    bin_valid,
  output logic                    bin_last,
  input  logic                    bin_ready,
  output logic                    busy,
  output logic                    frame_done,
`ifdef FFT_PEAK_HOLD_EN
  input  logic                    hold_clr,
`endif
  output logic                    ovf
);

  localparam int IW = $clog2(SIZE);
  localparam int SW = $clog2(SIZE*2) + 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam int LW = $clog2(LAT+1) + 1;

  localparam logic [SW-1:0] SMPL_LAST = SW'(SIZE*2 - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DIV - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LAT);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT      = 3'd2,
    ST_READ_LAT  = 3'd3,
    ST_READ_HOLD = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t        state_r;
  logic [SW-1:0] smpl_cnt_r;
  logic [DW-1:0] dec_cnt_r;
  logic [LW-1:0] lat_cnt_r;
  logic          arm_s;
  logic          stray_s;
  logic [RN-1:0] capture_s;

  // Frame start conditions and sample gating decoded from the current state
  always_comb begin
    arm_s   = 1'b0;
    stray_s = 1'b0;
    smpl_en = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arm_s = start & ~abort;
      end
      ST_FILL: begin
        smpl_en = smpl_valid & (dec_cnt_r == DEC_LAST);
      end
      ST_WAIT, ST_READ_LAT, ST_READ_HOLD: begin
        stray_s = smpl_valid;
      end
      ST_DONE: begin
        arm_s   = cont & ~abort;
        stray_s = smpl_valid;
      end
      default: begin
        arm_s   = 1'b0;
        stray_s = 1'b0;
        smpl_en = 1'b0;
      end
    endcase
  end

`ifdef FFT_PEAK_HOLD_EN
  logic [RN-1:0] peak_r [SIZE];
  logic          hold_clr_r;

  function automatic logic [RN-1:0] umax(input logic [RN-1:0] a, input logic [RN-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Captured bin value: raw data on a clearing frame, else the running peak
  always_comb begin
    capture_s = fft_data;
    if (hold_clr_r) begin
      capture_s = fft_data;
    end else begin
      capture_s = umax(fft_data, peak_r[bin_idx]);
    end
  end

  // Peak array update on each handshake and hold_clr latch at frame arm
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) begin
        peak_r[i] <= '0;
      end
      hold_clr_r <= 1'b0;
    end else begin
      if (arm_s) begin
        hold_clr_r <= hold_clr;
      end
      if (!abort && state_r == ST_READ_HOLD && bin_ready) begin
        peak_r[bin_idx] <= bin_data;
      end
    end
  end
`else
  // Captured bin value is the raw datapath magnitude
  always_comb begin
    capture_s = fft_data;
  end
`endif

  // Frame sequencer: state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      smpl_cnt_r <= '0;
      dec_cnt_r  <= '0;
      lat_cnt_r  <= '0;
      fft_shift  <= 1'b0;
      bin_data   <= '0;
      bin_idx    <= '0;
      bin_valid  <= 1'b0;
      bin_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else if (abort) begin
      // ovf deliberately survives an abort
      state_r    <= ST_IDLE;
      smpl_cnt_r <= '0;
      dec_cnt_r  <= '0;
      lat_cnt_r  <= '0;
      fft_shift  <= 1'b0;
      bin_idx    <= '0;
      bin_valid  <= 1'b0;
      bin_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fft_shift  <= 1'b0;
      frame_done <= 1'b0;
      if (stray_s) begin
        ovf <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (arm_s) begin
            state_r    <= ST_FILL;
            smpl_cnt_r <= '0;
            dec_cnt_r  <= '0;
            lat_cnt_r  <= '0;
            bin_idx    <= '0;
            busy       <= 1'b1;
            ovf        <= 1'b0;
          end
        end
        ST_FILL: begin
          if (smpl_valid) begin
            if (dec_cnt_r == DEC_LAST) begin
              dec_cnt_r  <= '0;
              smpl_cnt_r <= smpl_cnt_r + 1'b1;
              if (smpl_cnt_r == SMPL_LAST) begin
                state_r <= ST_WAIT;
              end
            end else begin
              dec_cnt_r <= dec_cnt_r + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (fft_done) begin
            state_r   <= ST_READ_LAT;
            fft_shift <= 1'b1;
            lat_cnt_r <= '0;
          end
        end
        ST_READ_LAT: begin
          if (lat_cnt_r == LAT_LAST) begin
            state_r   <= ST_READ_HOLD;
            bin_data  <= capture_s;
            bin_valid <= 1'b1;
            bin_last  <= (bin_idx == IDX_LAST);
          end else begin
            lat_cnt_r <= lat_cnt_r + 1'b1;
          end
        end
        ST_READ_HOLD: begin
          if (bin_ready) begin
            bin_valid <= 1'b0;
            bin_last  <= 1'b0;
            bin_idx   <= bin_idx + 1'b1;
            if (bin_idx == IDX_LAST) begin
              state_r    <= ST_DONE;
              frame_done <= 1'b1;
            end else begin
              state_r   <= ST_READ_LAT;
              fft_shift <= 1'b1;
              lat_cnt_r <= '0;
            end
          end
        end
        ST_DONE: begin
          bin_idx <= '0;
          if (arm_s) begin
            state_r    <= ST_FILL;
            smpl_cnt_r <= '0;
            dec_cnt_r  <= '0;
            lat_cnt_r  <= '0;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed-plus-random bench for fft_frame_ctrl with a latency-accurate FFT readout model.
module tb_fft_frame_ctrl;
  localparam int RN   = 16;
  localparam int SIZE = 8;
  localparam int LAT  = 2;
  localparam int IW   = $clog2(SIZE);

  logic clk = 1'b0;
  logic reset, start, cont, abort, smpl_valid, fft_done, bin_ready;
  logic [RN-1:0] fft_data;
  logic smpl_en, fft_shift, bin_valid, bin_last, busy, frame_done, ovf;
  logic [RN-1:0] bin_data;
  logic [IW-1:0] bin_idx;
  logic d3_smpl_en, d3_fft_shift, d3_bin_valid, d3_bin_last, d3_busy, d3_frame_done, d3_ovf;
  logic [RN-1:0] d3_bin_data;
  logic [IW-1:0] d3_bin_idx;
`ifdef FFT_PEAK_HOLD_EN
  logic hold_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic exp_ovf = 1'b0;
  logic [RN-1:0] vals [64];
  int pcnt;
  logic [LAT-1:0] sh;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.RN(RN), .SIZE(SIZE), .DIV(1), .LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
    .smpl_valid(smpl_valid), .smpl_en(smpl_en), .fft_done(fft_done), .fft_shift(fft_shift),
    .fft_data(fft_data), .bin_data(bin_data), .bin_idx(bin_idx), .bin_valid(bin_valid),
    .bin_last(bin_last), .bin_ready(bin_ready), .busy(busy), .frame_done(frame_done),
`ifdef FFT_PEAK_HOLD_EN
    .hold_clr(hold_clr),
`endif
    .ovf(ovf)
  );

  fft_frame_ctrl #(.RN(RN), .SIZE(SIZE), .DIV(3), .LAT(LAT)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
    .smpl_valid(smpl_valid), .smpl_en(d3_smpl_en), .fft_done(fft_done), .fft_shift(d3_fft_shift),
    .fft_data(fft_data), .bin_data(d3_bin_data), .bin_idx(d3_bin_idx), .bin_valid(d3_bin_valid),
    .bin_last(d3_bin_last), .bin_ready(bin_ready), .busy(d3_busy), .frame_done(d3_frame_done),
`ifdef FFT_PEAK_HOLD_EN
    .hold_clr(hold_clr),
`endif
    .ovf(d3_ovf)
  );

  // FFT readout model: the k-th shift pulse exposes vals[k] exactly LAT cycles later, junk otherwise
  always @(posedge clk) begin
    if (reset || start) pcnt <= 0;
    else if (fft_shift) pcnt <= pcnt + 1;
    if (reset) sh <= '0;
    else sh <= {sh[LAT-2:0], fft_shift};
  end

  always_comb begin
    if (sh[LAT-1] && pcnt > 0) fft_data = vals[(pcnt - 1) % 64];
    else fft_data = 16'hBAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    nxt();
    start = 1'b0;
  endtask

  task automatic fill(input int n, input int done_at);
    for (int i = 0; i < n; i++) begin
      smpl_valid = 1'b1;
      fft_done = (i == done_at);
      @(negedge clk);
      chk("fill_smpl_en", smpl_en, 1);
      chk("fill_busy", busy, 1);
      chk("fill_no_shift", fft_shift, 0);
      if (i == 0) chk("fill_ovf", ovf, exp_ovf);
      nxt();
    end
    smpl_valid = 1'b0;
    fft_done = 1'b0;
  endtask

  // Reads one frame; bins expected in order from vals[base], LAT+1 idle cycles between bins
  task automatic read_frame(input int base, input int stall_bin, input int abort_bin, input int ovf_bin);
    int waited;
    fft_done = 1'b1;
    nxt();
    fft_done = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      waited = 0;
      bin_ready = (i == stall_bin) ? 1'b0 : 1'b1;
      smpl_valid = (i == ovf_bin);
      @(negedge clk);
      while (!bin_valid && waited < 20) begin
        chk("shift_pulse", fft_shift, (waited == 0));
        if (i == ovf_bin && waited == 0) begin
          chk("ovf_no_smpl_en", smpl_en, 0);
          exp_ovf = 1'b1;
        end
        nxt();
        smpl_valid = 1'b0;
        waited++;
        @(negedge clk);
      end
      chk("bin_gap", waited, LAT + 1);
      if (!bin_valid) return;
      chk("bin_data", bin_data, vals[base + i]);
      chk("bin_idx", bin_idx, i);
      chk("bin_last", bin_last, (i == SIZE - 1));
      chk("bin_ovf", ovf, exp_ovf);
      if (i == abort_bin) begin
        abort = 1'b1;
        nxt();
        abort = 1'b0;
        bin_ready = 1'b1;
        @(negedge clk);
        chk("abort_valid", bin_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_shift", fft_shift, 0);
        chk("abort_ovf", ovf, exp_ovf);
        return;
      end
      if (i == stall_bin) begin
        for (int k = 1; k <= 5; k++) begin
          nxt();
          if (k == 5) bin_ready = 1'b1;
          @(negedge clk);
          chk("hold_valid", bin_valid, 1);
          chk("hold_data", bin_data, vals[base + i]);
          chk("hold_idx", bin_idx, i);
          chk("hold_no_shift", fft_shift, 0);
        end
      end
      nxt();
    end
    @(negedge clk);
    chk("frame_done", frame_done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", bin_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic sv;
    logic ov1;
    int acc1, acc3, str3;
    reset = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    smpl_valid = 1'b0; fft_done = 1'b0; bin_ready = 1'b0;
    for (int i = 0; i < 64; i++) vals[i] = RN'(10 * i);
    nxt(); nxt();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", bin_valid, 0);
    chk("rst_shift", fft_shift, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_idx", bin_idx, 0);
    chk("rst_data", bin_data, 0);
    chk("rst_last", bin_last, 0);
    chk("rst_d3_busy", d3_busy, 0);
    nxt();
    reset = 1'b0;

    // Frame 1: 16 back-to-back samples, a stray fft_done during fill, bins 10*idx
    do_start();
    fill(2 * SIZE, 4);
    read_frame(0, -1, -1, -1);
    nxt();
    @(negedge clk);
    chk("f1_idle_busy", busy, 0);
    chk("f1_frame_done_pulse", frame_done, 0);
    chk("f1_shift_count", pcnt, SIZE);
    nxt();

    // Random strobes: DIV=1 accepts every strobe, DIV=3 every third, extras flag ovf
    abort = 1'b1;
    nxt();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_d3_busy", d3_busy, 0);
    nxt();
    do_start();
    acc1 = 0; acc3 = 0; str3 = 0; ov1 = 1'b0;
    for (int c = 0; c < 600 && acc3 < 2 * SIZE; c++) begin
      sv = 1'($urandom_range(0, 1));
      smpl_valid = sv;
      @(negedge clk);
      chk("rnd_en1", smpl_en, sv && acc1 < 2 * SIZE);
      chk("rnd_en3", d3_smpl_en, sv && (str3 % 3 == 2));
      chk("rnd_ovf1", ovf, ov1);
      if (sv) begin
        if (acc1 < 2 * SIZE) acc1++;
        else ov1 = 1'b1;
        if (str3 % 3 == 2) acc3++;
        str3++;
      end
      nxt();
    end
    smpl_valid = 1'b1;
    @(negedge clk);
    chk("d3_wait_no_en", d3_smpl_en, 0);
    chk("d3_wait_busy", d3_busy, 1);
    nxt();
    smpl_valid = 1'b0;
    @(negedge clk);
    chk("d3_wait_ovf", d3_ovf, 1);
    nxt();
    abort = 1'b1;
    nxt();
    abort = 1'b0;
    @(negedge clk);
    chk("ovf_kept_by_abort", ovf, 1);
    nxt();

    // Frame with bin 3 back-pressured for five cycles; start clears ovf
    for (int i = 0; i < 64; i++) vals[i] = RN'($urandom);
    exp_ovf = 1'b0;
    do_start();
    fill(2 * SIZE, -1);
    read_frame(0, 3, -1, -1);
    nxt();
    @(negedge clk);
    chk("bp_idle_busy", busy, 0);
    nxt();

    // Continuous mode: two frames, stray sample in frame 1 READ keeps ovf set
    for (int i = 0; i < 64; i++) vals[i] = RN'($urandom);
    cont = 1'b1;
    do_start();
    fill(2 * SIZE, -1);
    read_frame(0, -1, -1, 2);
    nxt();
    cont = 1'b0;
    fill(2 * SIZE, -1);
    read_frame(SIZE, -1, -1, -1);
    nxt();
    @(negedge clk);
    chk("cont_idle_busy", busy, 0);
    chk("cont_ovf_sticky", ovf, 1);
    chk("cont_shift_count", pcnt, 2 * SIZE);
    nxt();

    // Abort at bin 4, then a clean frame from bin 0
    exp_ovf = 1'b0;
    do_start();
    fill(2 * SIZE, -1);
    read_frame(0, -1, 4, 1);
    nxt();
    for (int i = 0; i < 64; i++) vals[i] = RN'($urandom);
    exp_ovf = 1'b0;
    do_start();
    fill(2 * SIZE, -1);
    read_frame(0, -1, -1, -1);
    nxt();
    @(negedge clk);
    chk("final_idle_busy", busy, 0);
    chk("final_ovf", ovf, 0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
